// File: rtl/pll_seq_ctrl.sv
// PLL start-up / relock sequencer: power-cycles the PLL per divider request, filters LOCK, retries on timeout.
// Optional build macro PLL_SEQ_CTRL_HARD_RELOCK_EN: loss of lock re-runs the full EN power cycle with a fresh retry budget.
module pll_seq_ctrl #(
  parameter int unsigned DIS_CYCLES    = 4,
  parameter int unsigned LOCK_TIMEOUT  = 1000,
  parameter int unsigned LOCK_FILT     = 8,
  parameter int unsigned MAX_RETRY     = 3,
  parameter logic [7:0]  FBDIV_DEFAULT = 8'd10
) (
  input  logic       rclk,
  input  logic       rst_n,
  input  logic       sw_en,
  input  logic       cfg_valid,
  input  logic [7:0] cfg_fbdiv,
  output logic       cfg_ready,
  output logic       pll_en,
  output logic [7:0] pll_fbdiv,
  input  logic       pll_lock,
  output logic       locked,
  output logic       busy,
  output logic       err,
  output logic [3:0] retry_cnt,
  output logic       lol_seen
);
  localparam int DIS_W  = $clog2(DIS_CYCLES + 1);
  localparam int FILT_W = $clog2(LOCK_FILT + 1);
  localparam int TMO_W  = $clog2(LOCK_TIMEOUT + 1);

  localparam logic [DIS_W-1:0]  DIS_LAST  = DIS_W'(DIS_CYCLES - 1);
  localparam logic [DIS_W-1:0]  DIS_SAT   = DIS_W'(DIS_CYCLES);
  localparam logic [FILT_W-1:0] FILT_LAST = FILT_W'(LOCK_FILT - 1);
  localparam logic [FILT_W-1:0] FILT_SAT  = FILT_W'(LOCK_FILT);
  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(LOCK_TIMEOUT - 1);
  localparam logic [TMO_W-1:0]  TMO_SAT   = TMO_W'(LOCK_TIMEOUT);
  localparam logic [3:0]        RETRY_MAX = 4'(MAX_RETRY);

  typedef enum logic [2:0] {
    S_OFF     = 3'd0,
    S_DISABLE = 3'd1,
    S_WAIT    = 3'd2,
    S_LOCKED  = 3'd3,
    S_FAIL    = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [1:0]         sync_q;
  logic [DIS_W-1:0]   dis_cnt_q, dis_cnt_d;
  logic [FILT_W-1:0]  filt_cnt_q, filt_cnt_d;
  logic [TMO_W-1:0]   tmo_cnt_q, tmo_cnt_d;
  logic [7:0]         fbdiv_q, fbdiv_d;
  logic [3:0]         retry_q, retry_d;
  logic               lol_q, lol_d;
  logic               en_q, en_d;
  logic               locked_q, locked_d;
  logic               busy_q, busy_d;
  logic               err_q, err_d;
  logic               lock_s, hs, lock_hit, tmo_hit;

  assign lock_s    = sync_q[1];
  assign cfg_ready = rst_n & sw_en & (state_q inside {S_OFF, S_LOCKED, S_FAIL});
  assign hs        = cfg_valid & cfg_ready;
  // Hits are taken on the edge where the counter would reach its target.
  assign lock_hit  = lock_s && (filt_cnt_q == FILT_LAST);
  assign tmo_hit   = (tmo_cnt_q == TMO_LAST);

  always_comb begin
    state_d    = state_q;
    fbdiv_d    = fbdiv_q;
    retry_d    = retry_q;
    lol_d      = lol_q;
    dis_cnt_d  = '0;
    filt_cnt_d = '0;
    tmo_cnt_d  = '0;

    if (!sw_en) begin
      state_d = S_OFF;
    end else if (hs) begin
      state_d = S_DISABLE;
      fbdiv_d = cfg_fbdiv;
      retry_d = '0;
      lol_d   = 1'b0;
    end else begin
      case (state_q)
        S_DISABLE: if (dis_cnt_q == DIS_LAST) state_d = S_WAIT;
        S_WAIT: begin
          if (lock_hit) begin
            state_d = S_LOCKED;
          end else if (tmo_hit) begin
            if (retry_q < RETRY_MAX) begin
              retry_d = retry_q + 4'd1;
              state_d = S_DISABLE;
            end else begin
              state_d = S_FAIL;
            end
          end
        end
        S_LOCKED: begin
          if (!lock_s) begin
            lol_d = 1'b1;
`ifdef PLL_SEQ_CTRL_HARD_RELOCK_EN
            state_d = S_DISABLE;
            retry_d = '0;
`else
            state_d = S_WAIT;
`endif
          end
        end
        default: ;
      endcase
    end

    // Counters run only while the state is held; any transition restarts them from zero.
    if (state_d == state_q) begin
      if (state_q == S_DISABLE) begin
        dis_cnt_d = (dis_cnt_q == DIS_SAT) ? dis_cnt_q : dis_cnt_q + DIS_W'(1);
      end
      if (state_q == S_WAIT) begin
        if (lock_s) filt_cnt_d = (filt_cnt_q == FILT_SAT) ? filt_cnt_q : filt_cnt_q + FILT_W'(1);
        tmo_cnt_d = (tmo_cnt_q == TMO_SAT) ? tmo_cnt_q : tmo_cnt_q + TMO_W'(1);
      end
    end

    en_d     = (state_d == S_WAIT) || (state_d == S_LOCKED);
    locked_d = (state_d == S_LOCKED);
    busy_d   = (state_d == S_DISABLE) || (state_d == S_WAIT);
    err_d    = (state_d == S_FAIL);
  end

  always_ff @(posedge rclk) begin
    if (!rst_n) begin
      state_q    <= S_OFF;
      sync_q     <= '0;
      dis_cnt_q  <= '0;
      filt_cnt_q <= '0;
      tmo_cnt_q  <= '0;
      fbdiv_q    <= FBDIV_DEFAULT;
      retry_q    <= '0;
      lol_q      <= 1'b0;
      en_q       <= 1'b0;
      locked_q   <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync_q     <= {sync_q[0], pll_lock};
      dis_cnt_q  <= dis_cnt_d;
      filt_cnt_q <= filt_cnt_d;
      tmo_cnt_q  <= tmo_cnt_d;
      fbdiv_q    <= fbdiv_d;
      retry_q    <= retry_d;
      lol_q      <= lol_d;
      en_q       <= en_d;
      locked_q   <= locked_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
    end
  end

  assign pll_en    = en_q;
  assign pll_fbdiv = fbdiv_q;
  assign locked    = locked_q;
  assign busy      = busy_q;
  assign err       = err_q;
  assign retry_cnt = retry_q;
  assign lol_seen  = lol_q;

endmodule

// File: tb/tb_pll_seq_ctrl.sv
// Bench for pll_seq_ctrl: expected output-change events are queued by the stimulus and matched by a monitor.
module tb_pll_seq_ctrl;
  logic       rclk;
  logic       rst_n;
  logic       sw_en;
  logic       cfg_valid;
  logic [7:0] cfg_fbdiv;
  logic       cfg_ready;
  logic       pll_en;
  logic [7:0] pll_fbdiv;
  logic       pll_lock;
  logic       locked;
  logic       busy;
  logic       err;
  logic [3:0] retry_cnt;
  logic       lol_seen;

  pll_seq_ctrl #(
    .DIS_CYCLES   (4),
    .LOCK_TIMEOUT (100),
    .LOCK_FILT    (8),
    .MAX_RETRY    (3),
    .FBDIV_DEFAULT(8'd10)
  ) dut (
    .rclk     (rclk),
    .rst_n    (rst_n),
    .sw_en    (sw_en),
    .cfg_valid(cfg_valid),
    .cfg_fbdiv(cfg_fbdiv),
    .cfg_ready(cfg_ready),
    .pll_en   (pll_en),
    .pll_fbdiv(pll_fbdiv),
    .pll_lock (pll_lock),
    .locked   (locked),
    .busy     (busy),
    .err      (err),
    .retry_cnt(retry_cnt),
    .lol_seen (lol_seen)
  );

  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;

  initial begin
    rclk = 1'b0;
    forever #5 rclk = ~rclk;
  end

  always @(posedge rclk) cyc <= cyc + 1;

  // Expected observation: {cfg_ready, pll_en, locked, busy, err, lol_seen, retry_cnt, pll_fbdiv}
  int          q_cyc[$];
  logic [17:0] q_vec[$];
  string       q_nm[$];

  logic       e_rdy, e_en, e_lk, e_bs, e_er, e_lol;
  logic [3:0] e_rc;
  logic [7:0] e_fb;

  task automatic ev(input int c, input string nm);
    q_cyc.push_back(c);
    q_vec.push_back({e_rdy, e_en, e_lk, e_bs, e_er, e_lol, e_rc, e_fb});
    q_nm.push_back(nm);
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge rclk);
  endtask

  bit          mon_on = 0;
  bit          first = 1;
  logic [17:0] prev;
  logic [17:0] obs;

  initial begin
    forever begin
      @(posedge rclk);
      #1;
      if (mon_on) begin
        obs = {cfg_ready, pll_en, locked, busy, err, lol_seen, retry_cnt, pll_fbdiv};
        while (q_cyc.size() > 0 && q_cyc[0] < cyc) begin
          n_tests++;
          n_fail++;
          $display("FAIL %s: no output change at cycle %0d, outputs 0x%05h, required 0x%05h",
                   q_nm[0], q_cyc[0], obs, q_vec[0]);
          void'(q_cyc.pop_front());
          void'(q_vec.pop_front());
          void'(q_nm.pop_front());
        end
        if (first || obs != prev) begin
          n_tests++;
          if (q_cyc.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected: outputs changed to 0x%05h at cycle %0d, required no change", obs, cyc);
          end else begin
            if (q_cyc[0] != cyc || q_vec[0] != obs) begin
              n_fail++;
              $display("FAIL %s: got 0x%05h at cycle %0d, required 0x%05h at cycle %0d",
                       q_nm[0], obs, cyc, q_vec[0], q_cyc[0]);
            end
            void'(q_cyc.pop_front());
            void'(q_vec.pop_front());
            void'(q_nm.pop_front());
          end
          prev  = obs;
          first = 0;
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d, required completion", cyc);
    $fatal(1, "watchdog");
  end

  int a, b, c, t;

  initial begin
    rst_n = 1'b0; sw_en = 1'b0; cfg_valid = 1'b0; cfg_fbdiv = 8'd0; pll_lock = 1'b0;
    e_rdy = 0; e_en = 0; e_lk = 0; e_bs = 0; e_er = 0; e_lol = 0; e_rc = 4'd0; e_fb = 8'd10;

    // Reset state, then cfg_ready once sw_en rises.
    repeat (3) @(negedge rclk);
    ev(cyc + 1, "reset_state");
    mon_on = 1;
    @(negedge rclk);
    rst_n = 1'b1; sw_en = 1'b1;
    e_rdy = 1; ev(cyc + 1, "ready_after_reset");

    // Start-up: fbdiv 25, lock rises ~20 cycles after EN.
    @(negedge rclk);
    c = cyc; t = c + 1;
    e_rdy = 0; e_bs = 1; e_fb = 8'd25; ev(t, "hs25_disable");
    e_en = 1; ev(t + 4, "hs25_enable");
    e_lk = 1; e_bs = 0; e_rdy = 1; ev(t + 33, "hs25_locked");
    cfg_valid = 1'b1; cfg_fbdiv = 8'd25;
    @(negedge rclk);
    cfg_valid = 1'b0;
    wait_cyc(t + 23);
    pll_lock = 1'b1;
    wait_cyc(t + 40);

    // One-cycle loss of lock while LOCKED.
    a = cyc;
    pll_lock = 1'b0;
`ifdef PLL_SEQ_CTRL_HARD_RELOCK_EN
    e_en = 0; e_lk = 0; e_bs = 1; e_lol = 1; e_rdy = 0; ev(a + 3, "lol_disable");
    e_en = 1; ev(a + 7, "lol_reenable");
    e_lk = 1; e_bs = 0; e_rdy = 1; ev(a + 15, "lol_relock");
`else
    e_lk = 0; e_bs = 1; e_lol = 1; e_rdy = 0; ev(a + 3, "lol_detect");
    e_lk = 1; e_bs = 0; e_rdy = 1; ev(a + 11, "lol_relock");
`endif
    @(negedge rclk);
    pll_lock = 1'b1;
    wait_cyc(a + 20);

    // Handshake fbdiv 40 on the same edge that loss of lock is seen: new sequence wins.
    b = cyc;
    pll_lock = 1'b0;
    e_en = 0; e_lk = 0; e_bs = 1; e_lol = 0; e_rdy = 0; e_fb = 8'd40; ev(b + 3, "hs40_disable");
    e_en = 1; ev(b + 7, "hs40_enable");
    e_lk = 1; e_bs = 0; e_rdy = 1; ev(b + 15, "hs40_locked");
    @(negedge rclk);
    pll_lock = 1'b1;
    @(negedge rclk);
    cfg_valid = 1'b1; cfg_fbdiv = 8'd40;
    @(negedge rclk);
    cfg_valid = 1'b0;
    wait_cyc(b + 20);

    // sw_en drop with a same-cycle request during WAIT_LOCK.
    c = cyc; t = c + 1;
    e_en = 0; e_lk = 0; e_bs = 1; e_rdy = 0; e_fb = 8'd50; ev(t, "hs50_disable");
    e_en = 1; ev(t + 4, "hs50_enable");
    e_en = 0; e_bs = 0; ev(t + 11, "swoff_off");
    e_rdy = 1; ev(t + 13, "swon_ready");
    cfg_valid = 1'b1; cfg_fbdiv = 8'd50; pll_lock = 1'b0;
    @(negedge rclk);
    cfg_valid = 1'b0;
    wait_cyc(t + 10);
    sw_en = 1'b0; cfg_valid = 1'b1; cfg_fbdiv = 8'd99;
    @(negedge rclk);
    cfg_valid = 1'b0;
    @(negedge rclk);
    sw_en = 1'b1;
    wait_cyc(t + 16);

    // Lock never arrives: four timeout windows, then FAIL.
    c = cyc; t = c + 1;
    e_bs = 1; e_rdy = 0; e_fb = 8'd60; ev(t, "hs60_disable");
    for (int k = 0; k < 4; k++) begin
      e_en = 1; e_rc = 4'(k); ev(t + 4 + 104 * k, $sformatf("tmo_enable%0d", k));
      if (k < 3) begin
        e_en = 0; e_rc = 4'(k + 1); ev(t + 104 + 104 * k, $sformatf("tmo_retry%0d", k + 1));
      end else begin
        e_en = 0; e_bs = 0; e_er = 1; e_rdy = 1; ev(t + 416, "tmo_fail");
      end
    end
    cfg_valid = 1'b1; cfg_fbdiv = 8'd60;
    @(negedge rclk);
    cfg_valid = 1'b0;
    wait_cyc(t + 420);

    // Glitchy lock 1,1,1,0 never passes the filter; the timeout path is taken.
    c = cyc; t = c + 1;
    e_bs = 1; e_er = 0; e_rdy = 0; e_rc = 4'd0; e_fb = 8'd70; ev(t, "hs70_disable");
    e_en = 1; ev(t + 4, "glitch_enable");
    e_en = 0; e_rc = 4'd1; ev(t + 104, "glitch_timeout");
    e_en = 1; ev(t + 108, "glitch_reenable");
    cfg_valid = 1'b1; cfg_fbdiv = 8'd70;
    @(negedge rclk);
    cfg_valid = 1'b0;
    while (cyc < t + 103) begin
      @(negedge rclk);
      pll_lock = ((cyc - t) % 4) != 3;
    end
    pll_lock = 1'b0;
    wait_cyc(t + 112);

    n_tests++;
    if (q_cyc.size() != 0) begin
      n_fail++;
      $display("FAIL leftover: %0d expected events outstanding, required 0", q_cyc.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
